// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and counter widths for the serial pattern transmitter.
// Optional parity is controlled by SERIAL_PATTERN_TX_PARITY_EN in the top module.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } tx_state_t;

    localparam int BIT_CNT_W = 5;
    localparam int GAP_CNT_W = 4;
    localparam int REP_CNT_W = 4;

endpackage

// File: rtl/serial_pattern_tx_shreg.sv
// Loadable MSB-first shift register. It exposes the current MSB and the bit
// that becomes MSB after the next shift, so the line can be driven from a flop.
module serial_pattern_tx_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             msb_next
);

    logic [WIDTH-1:0] q;

    // Load wins over shift; zeros enter from the LSB end.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb      = q[WIDTH-1];
    assign msb_next = q[WIDTH-2];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB first, repeated with idle gaps.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to every repetition.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int GAP_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [3:0]         reps,
    output logic               w,
    output logic               busy,
    output logic               done
);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int BW = PAT_LEN + 1;
`else
    localparam int BW = PAT_LEN;
`endif

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BW - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(GAP_LEN - 1);
    localparam logic [REP_CNT_W-1:0] ONE_REP  = REP_CNT_W'(1);

    // One repetition as it appears on the line, parity bit (if any) last.
    function automatic logic [BW-1:0] frame(input logic [PAT_LEN-1:0] pat);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        return {pat, ^pat};
`else
        return pat;
`endif
    endfunction

    tx_state_t              state, state_nxt;
    logic [PAT_LEN-1:0]     pat_q, pat_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
    logic [GAP_CNT_W-1:0]   gap_cnt, gap_nxt;
    logic [REP_CNT_W-1:0]   rep_cnt, rep_nxt;
    logic                   w_nxt, busy_nxt, done_nxt;
    logic                   sh_load, sh_shift, sh_msb, sh_msb_next;
    logic [BW-1:0]          sh_din;

    serial_pattern_tx_shreg #(
        .WIDTH (BW)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .shift    (sh_shift),
        .din      (sh_din),
        .msb      (sh_msb),
        .msb_next (sh_msb_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rep_cnt <= '0;
            w       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pat_q   <= pat_nxt;
            bit_cnt <= bit_nxt;
            gap_cnt <= gap_nxt;
            rep_cnt <= rep_nxt;
            w       <= w_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // w is computed one cycle ahead so the line is a plain flop output:
    // entering SEND shows the new MSB, staying in SEND shows the bit below it.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        rep_nxt   = rep_cnt;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_din    = frame(pat_q);
        w_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEND;
                    pat_nxt   = pattern;
                    rep_nxt   = (reps == '0) ? ONE_REP : reps;
                    bit_nxt   = '0;
                    sh_load   = 1'b1;
                    sh_din    = frame(pattern);
                    w_nxt     = sh_din[BW-1];
                end
            end
            SEND: begin
                if (bit_cnt == LAST_BIT) begin
                    rep_nxt = rep_cnt - 1'b1;
                    if (rep_cnt > ONE_REP) begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                        sh_load   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    bit_nxt  = bit_cnt + 1'b1;
                    sh_shift = 1'b1;
                    w_nxt    = sh_msb_next;
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = SEND;
                    bit_nxt   = '0;
                    w_nxt     = sh_msb;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a queue-based line model checked every cycle,
// plus directed transfers with literal expectations (honours SERIAL_PATTERN_TX_PARITY_EN).
module tb_serial_pattern_tx;

    localparam int PAT_LEN = 4;
    localparam int GAP_LEN = 2;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam bit          PAR = 1'b1;
    localparam int          BB  = 5;
    localparam logic [31:0] T1W = 32'b10111;
    localparam logic [31:0] T2W = 32'b101110010111;
    localparam logic [31:0] T3W = 32'b01100;
    localparam logic [31:0] T6W = 32'b10010;
`else
    localparam bit          PAR = 1'b0;
    localparam int          BB  = 4;
    localparam logic [31:0] T1W = 32'b1011;
    localparam logic [31:0] T2W = 32'b1011001011;
    localparam logic [31:0] T3W = 32'b0110;
    localparam logic [31:0] T6W = 32'b1001;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic       w, busy, done;

    int errors = 0;
    int checks = 0;

    serial_pattern_tx #(
        .PAT_LEN (PAT_LEN),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .w       (w),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rst, input logic [3:0] pat, input logic [3:0] rp);
        start   = st;
        reset   = rst;
        pattern = pat;
        reps    = rp;
    endtask

    // Model: each accepted start expands into the full per-cycle {w,busy,done} trace.
    typedef logic [2:0] exp_t;
    exp_t q[$];
    exp_t expNow = '0;
    bit   modelValid = 1'b0;

    function automatic void buildSequence(input logic [3:0] pat, input logic [3:0] rp);
        int rr;
        rr = (rp == 4'd0) ? 1 : int'(rp);
        for (int r = 0; r < rr; r++) begin
            for (int i = 0; i < PAT_LEN; i++) q.push_back({pat[PAT_LEN-1-i], 1'b1, 1'b0});
            if (PAR) q.push_back({^pat, 1'b1, 1'b0});
            if (r < rr - 1) for (int g = 0; g < GAP_LEN; g++) q.push_back(3'b010);
        end
        q.push_back(3'b011);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            expNow = '0;
        end else begin
            if (!expNow[1] && start) buildSequence(pattern, reps);
            if (q.size() > 0) expNow = q.pop_front();
            else expNow = '0;
        end
        modelValid = 1'b1;
    end

    always @(negedge clk) begin
        if (modelValid) checkOutput("cycle {w,busy,done}", {29'd0, w, busy, done}, {29'd0, expNow});
    end

    // Per-transfer traces, index = edge number relative to the first stimulus edge.
    logic        wArr[32];
    logic        busyArr[32];
    logic [31:0] doneTr;
    int          busyCnt;

    task automatic stepEdge(input int idx);
        @(posedge clk);
        #1;
        wArr[idx]    = w;
        busyArr[idx] = busy;
        doneTr[idx]  = done;
        busyCnt     += int'(busy);
    endtask

    task automatic runSeq(input logic [3:0] pat0, input logic [3:0] patLater, input logic [3:0] rp,
                          input logic [31:0] startMask, input logic [31:0] resetMask, input int n);
        doneTr  = '0;
        busyCnt = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(startMask[i], resetMask[i], (i == 0) ? pat0 : patLater, rp);
            stepEdge(i);
        end
        applyStimulus(1'b0, 1'b0, patLater, rp);
    endtask

    function automatic logic [31:0] firstBits(input int s, input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r = {r[30:0], wArr[s+i]};
        return r;
    endfunction

    initial begin
        logic [31:0] m;
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", {29'd0, w, busy, done}, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
        @(posedge clk);
        #1;

        // Single repetition
        runSeq(4'b1011, 4'b1011, 4'd1, 32'd1, 32'd0, 8);
        checkOutput("t1 bits", firstBits(0, BB), T1W);
        checkOutput("t1 done edge", doneTr, 32'd1 << BB);
        checkOutput("t1 busy cycles", busyCnt, BB + 1);

        // Two repetitions with gap
        runSeq(4'b1011, 4'b1011, 4'd2, 32'd1, 32'd0, 16);
        checkOutput("t2 bits", firstBits(0, 2 * BB + GAP_LEN), T2W);
        checkOutput("t2 done edge", doneTr, 32'd1 << (2 * BB + GAP_LEN));
        checkOutput("t2 busy cycles", busyCnt, 2 * BB + GAP_LEN + 1);

        // reps=0 behaves as reps=1
        runSeq(4'b0110, 4'b0110, 4'd0, 32'd1, 32'd0, 8);
        checkOutput("t3 bits", firstBits(0, BB), T3W);
        checkOutput("t3 done edge", doneTr, 32'd1 << BB);
        checkOutput("t3 busy cycles", busyCnt, BB + 1);

        // Starts while busy (including the DONE cycle) are ignored
        m = 32'd1 | (32'd1 << 2);
        for (int k = 3; k <= BB + 1; k++) m |= (32'd1 << k);
        runSeq(4'b1011, 4'b0000, 4'd1, m, 32'd0, 12);
        checkOutput("t4 bits", firstBits(0, BB), T1W);
        checkOutput("t4 done edge", doneTr, 32'd1 << BB);
        checkOutput("t4 busy cycles", busyCnt, BB + 1);

        // Reset mid-SEND, then clean restart
        runSeq(4'b1011, 4'b1011, 4'd1, (32'd1 | (32'd1 << 4)), (32'd1 << 2), 14);
        checkOutput("t5 w after reset", {31'd0, wArr[2]}, 32'd0);
        checkOutput("t5 busy after reset", {31'd0, busyArr[2]}, 32'd0);
        checkOutput("t5 restart bits", firstBits(4, BB), T1W);
        checkOutput("t5 done edge", doneTr, 32'd1 << (4 + BB));
        checkOutput("t5 busy cycles", busyCnt, 2 + BB + 1);

        // Parity-sensitive pattern
        runSeq(4'b1001, 4'b1001, 4'd1, 32'd1, 32'd0, 8);
        checkOutput("t6 bits", firstBits(0, BB), T6W);
        checkOutput("t6 done edge", doneTr, 32'd1 << BB);

        // start together with reset: reset wins
        runSeq(4'b1111, 4'b1111, 4'd1, 32'd1, 32'd1, 4);
        checkOutput("t7 busy cycles", busyCnt, 0);
        checkOutput("t7 done", doneTr, 32'd0);

        // Three repetitions, model-checked, plus total length
        runSeq(4'b1100, 4'b0011, 4'd3, 32'd1, 32'd0, 24);
        checkOutput("t8 busy cycles", busyCnt, 3 * BB + 2 * GAP_LEN + 1);
        checkOutput("t8 done count", $countones(doneTr), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
